// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and responder state type, used by the memory
// responder and by the DMA channel controller's master port.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE    = 2'b00;
    localparam logic [1:0] HTRANS_BUSY    = 2'b01;
    localparam logic [1:0] HTRANS_NON_SEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ     = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } resp_state_e;

    // Little-endian lane mask; only meaningful for legal (aligned) sizes.
    function automatic logic [3:0] byte_enables(input logic [1:0] offs, input logic [2:0] size);
        case (size)
            HSIZE_BYTE: return 4'b0001 << offs;
            HSIZE_HALF: return offs[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between one master and the memory responder.
interface ahb_slave_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic              HREADYOUT;
    logic [DATA_W-1:0] HRDATA;
    logic [1:0]        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );

endinterface

// File: rtl/ahb_mem_array.sv
// Word-organised storage: combinational read, synchronous byte-enabled write.
// Contents are deliberately not reset.
module ahb_mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder: programmable wait states, byte/halfword/word
// lanes, two-cycle ERROR for out-of-range, oversized or misaligned accesses.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst,
    ahb_slave_mem_if.slave  bus
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [ADDR_W:0] BASE_EXT = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] LIMIT    = BASE_EXT + (ADDR_W+1)'(4 * DEPTH);
    localparam logic [2:0]      WS       = 3'(WAIT_STATES);

    resp_state_e   state_q, state_d;
    logic [2:0]    wcnt_q,  wcnt_d;
    logic [AW-1:0] word_q,  word_d;
    logic [3:0]    be_q,    be_d;
    logic          write_q, write_d;

    logic              accept;
    logic              addr_err;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    always_comb begin
        addr_err = ({1'b0, bus.HADDR} < BASE_EXT) || ({1'b0, bus.HADDR} >= LIMIT)
                || (bus.HSIZE > HSIZE_WORD)
                || (bus.HSIZE == HSIZE_HALF && bus.HADDR[0])
                || (bus.HSIZE == HSIZE_WORD && bus.HADDR[1:0] != 2'b00);
    end

    // Only states that can close a data phase may take a new address phase.
    assign accept = bus.HSEL && bus.HREADY
                 && (bus.HTRANS == HTRANS_NON_SEQ || bus.HTRANS == HTRANS_SEQ)
                 && (state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        word_d  = word_q;
        be_d    = be_q;
        write_d = write_q;
        case (state_q)
            S_WAIT: begin
                if (wcnt_q == 3'd1) state_d = S_DATA;
                wcnt_d = wcnt_q - 3'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    word_d  = AW'((bus.HADDR - BASE_ADDR) >> 2);
                    be_d    = byte_enables(bus.HADDR[1:0], bus.HSIZE);
                    write_d = bus.HWRITE && !addr_err;
                    if (addr_err) begin
                        state_d = S_ERR1;
                    end else if (WS != 3'd0) begin
                        state_d = S_WAIT;
                        wcnt_d  = WS;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            word_q  <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            word_q  <= word_d;
            be_q    <= be_d;
            write_q <= write_d;
        end
    end

    // The commit is gated by the async-reset state, so reset drops a pending write.
    assign mem_we = (state_q == S_DATA) && write_q;

    ahb_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (be_q),
        .addr  (word_q),
        .wdata (bus.HWDATA),
        .rdata (mem_rdata)
    );

    assign bus.HREADYOUT = !(state_q == S_WAIT || state_q == S_ERR1);
    assign bus.HRESP     = (state_q == S_ERR1 || state_q == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign bus.HRDATA    = (state_q == S_DATA) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three responders (0, 2 and 3 wait states) on one
// pipelined master, checked against a byte-level memory model.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    localparam int DEPTH = 256;

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        int          waits;
        logic [1:0]  resp_first;
        logic [1:0]  resp_last;
        logic [31:0] rdata;
        bit          idle_zero;
        bit          chk_rd;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    int          dsel;

    logic        obs_ready;
    logic [1:0]  obs_resp;
    logic [31:0] obs_rdata;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    xfer_t       xq[$];
    obs_t        oq[$];
    bit          timed_out;
    int          burst_cycles;
    logic [31:0] mdl [3][DEPTH];

    always #5 clk = ~clk;

    ahb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    ahb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    ahb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    assign bus0.HSEL   = hsel && (dsel == 0);
    assign bus0.HADDR  = haddr;
    assign bus0.HTRANS = htrans;
    assign bus0.HWRITE = hwrite;
    assign bus0.HSIZE  = hsize;
    assign bus0.HWDATA = hwdata;
    assign bus0.HREADY = bus0.HREADYOUT;

    assign bus1.HSEL   = hsel && (dsel == 1);
    assign bus1.HADDR  = haddr;
    assign bus1.HTRANS = htrans;
    assign bus1.HWRITE = hwrite;
    assign bus1.HSIZE  = hsize;
    assign bus1.HWDATA = hwdata;
    assign bus1.HREADY = bus1.HREADYOUT;

    assign bus2.HSEL   = hsel && (dsel == 2);
    assign bus2.HADDR  = haddr;
    assign bus2.HTRANS = htrans;
    assign bus2.HWRITE = hwrite;
    assign bus2.HSIZE  = hsize;
    assign bus2.HWDATA = hwdata;
    assign bus2.HREADY = bus2.HREADYOUT;

    ahb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    ahb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(2))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    ahb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(3))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always_comb begin
        case (dsel)
            0:       begin obs_ready = bus0.HREADYOUT; obs_resp = bus0.HRESP; obs_rdata = bus0.HRDATA; end
            1:       begin obs_ready = bus1.HREADYOUT; obs_resp = bus1.HRESP; obs_rdata = bus1.HRDATA; end
            default: begin obs_ready = bus2.HREADYOUT; obs_resp = bus2.HRESP; obs_rdata = bus2.HRDATA; end
        endcase
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 2 : 3;
    endfunction

    function automatic xfer_t mk(input bit sel, input logic [1:0] trans, input bit wr,
                                 input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.wr = wr; x.size = size; x.addr = addr; x.wdata = wdata;
        return x;
    endfunction

    function automatic obs_t obs_init();
        obs_t o;
        o.waits = 0; o.resp_first = HRESP_OKAY; o.resp_last = HRESP_OKAY;
        o.rdata = '0; o.idle_zero = 1'b1; o.chk_rd = 1'b1;
        return o;
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t       x;
        int unsigned k;
        logic [31:0] mask;
        k       = $urandom_range(0, 15);
        x.sel   = (k != 0);
        x.trans = (k == 1) ? HTRANS_IDLE : (k == 2) ? HTRANS_BUSY : (k[0] ? HTRANS_SEQ : HTRANS_NON_SEQ);
        x.wr    = 1'($urandom_range(0, 1));
        x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        x.addr  = ($urandom_range(0, 9) == 0) ? 32'(4 * DEPTH) + 32'($urandom_range(0, 63))
                                              : 32'($urandom_range(0, 4 * DEPTH - 1));
        if (x.size <= 3'd2 && $urandom_range(0, 4) != 0) begin
            mask   = (32'd1 << x.size) - 32'd1;
            x.addr = x.addr & ~mask;
        end
        x.wdata = $urandom;
        return x;
    endfunction

    // Reference: what the bus should show for one transfer; updates the model on legal writes.
    function automatic obs_t model_step(input int d, input xfer_t x);
        obs_t e;
        int   w, lane, nb;
        bit   bad;
        e = obs_init();
        if (!(x.sel && (x.trans == HTRANS_NON_SEQ || x.trans == HTRANS_SEQ))) return e;
        bad = (x.addr >= 32'(4 * DEPTH)) || (x.size > 3'd2)
           || (x.size == 3'd1 && x.addr % 2 != 0) || (x.size == 3'd2 && x.addr % 4 != 0);
        if (bad) begin
            e.waits = 1; e.resp_first = HRESP_ERROR; e.resp_last = HRESP_ERROR;
            return e;
        end
        e.waits = ws_of(d);
        w = int'(x.addr / 4);
        if (x.wr) begin
            e.chk_rd = 1'b0;
            nb = 1 << x.size;
            for (int k = 0; k < nb; k++) begin
                lane = int'(x.addr % 4) + k;
                mdl[d][w][8*lane +: 8] = x.wdata[8*lane +: 8];
            end
        end else begin
            e.rdata = mdl[d][w];
        end
        return e;
    endfunction

    // Pipelined master: plays xq to responder d, records every data phase into oq.
    task automatic run_xfers(input int d);
        int    idx, cyc, first_edge, last_edge;
        bit    dp_v, started, r;
        logic [1:0]  p;
        logic [31:0] rd;
        xfer_t dp;
        obs_t  o;
        idx = 0; cyc = 0; first_edge = 0; last_edge = 0; dp_v = 0; started = 0;
        o = obs_init(); dp = mk(0, HTRANS_IDLE, 0, 3'd0, 32'd0, 32'd0);
        dsel = d; oq.delete(); timed_out = 0;
        while (1) begin
            if (idx < xq.size()) begin
                hsel = xq[idx].sel; htrans = xq[idx].trans; hwrite = xq[idx].wr;
                hsize = xq[idx].size; haddr = xq[idx].addr;
            end else begin
                hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = 3'd0; haddr = $urandom;
            end
            hwdata = (dp_v && dp.wr) ? dp.wdata : $urandom;
            @(negedge clk);
            r = obs_ready; p = obs_resp; rd = obs_rdata;
            if (dp_v) begin
                if (!r) begin
                    if (o.waits == 0) o.resp_first = p;
                    o.waits++;
                    if (rd !== 32'd0) o.idle_zero = 1'b0;
                end else begin
                    o.resp_last = p; o.rdata = rd;
                    oq.push_back(o);
                    dp_v = 0; last_edge = cyc + 1;
                end
            end
            if (r && idx < xq.size()) begin
                dp = xq[idx]; idx++; dp_v = 1; o = obs_init();
                if (!started) begin started = 1; first_edge = cyc + 1; end
            end
            @(posedge clk); cyc++; #1;
            if (!dp_v && idx >= xq.size()) break;
            if (cyc > 16 * xq.size() + 32) begin timed_out = 1; break; end
        end
        hsel = 1'b0; htrans = HTRANS_IDLE;
        burst_cycles = last_edge - first_edge;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus0.HREADYOUT !== 1'b1 || bus0.HRESP !== 2'b00 || bus0.HRDATA !== 32'd0)
            $display("FAIL reset_dut0: got ready=%b resp=%b rdata=%h, want 1/00/0", bus0.HREADYOUT, bus0.HRESP, bus0.HRDATA);
        else n_pass++;
        n_checks++; if (bus1.HREADYOUT !== 1'b1 || bus1.HRESP !== 2'b00 || bus1.HRDATA !== 32'd0)
            $display("FAIL reset_dut1: got ready=%b resp=%b rdata=%h, want 1/00/0", bus1.HREADYOUT, bus1.HRESP, bus1.HRDATA);
        else n_pass++;
        n_checks++; if (bus2.HREADYOUT !== 1'b1 || bus2.HRESP !== 2'b00 || bus2.HRDATA !== 32'd0)
            $display("FAIL reset_dut2: got ready=%b resp=%b rdata=%h, want 1/00/0", bus2.HREADYOUT, bus2.HRESP, bus2.HRDATA);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_rw();
        obs_t e;
        for (int d = 0; d < 3; d++) begin
            xq.delete();
            for (int w = 0; w < DEPTH; w++) xq.push_back(mk(1, HTRANS_NON_SEQ, 1, HSIZE_WORD, 32'(4 * w), $urandom));
            for (int w = 0; w < DEPTH; w++) xq.push_back(mk(1, HTRANS_SEQ, 0, HSIZE_WORD, 32'(4 * w), 32'd0));
            if (d == 0) begin
                xq.push_back(mk(1, HTRANS_NON_SEQ, 1, HSIZE_WORD, 32'h10, 32'hDEADBEEF));
                xq.push_back(mk(1, HTRANS_NON_SEQ, 0, HSIZE_WORD, 32'h10, 32'd0));
            end
            run_xfers(d);
            n_checks++;
            if (timed_out || oq.size() != xq.size())
                $display("FAIL word_rw_complete: got %0d of %0d phases", oq.size(), xq.size());
            else n_pass++;
            foreach (oq[i]) begin
                e = model_step(d, xq[i]);
                n_checks++;
                if (oq[i].waits !== e.waits || oq[i].resp_first !== e.resp_first || oq[i].resp_last !== e.resp_last || oq[i].idle_zero !== 1'b1)
                    $display("FAIL word_rw_resp d%0d[%0d]: got waits=%0d resp=%b/%b, want waits=%0d resp=%b/%b",
                             d, i, oq[i].waits, oq[i].resp_first, oq[i].resp_last, e.waits, e.resp_first, e.resp_last);
                else n_pass++;
                if (e.chk_rd) begin
                    n_checks++;
                    if (oq[i].rdata !== e.rdata) $display("FAIL word_rw_data d%0d[%0d]: got %h, want %h", d, i, oq[i].rdata, e.rdata);
                    else n_pass++;
                end
            end
            if (d == 0 && oq.size() == xq.size()) begin
                n_checks++;
                if (oq[oq.size()-1].rdata !== 32'hDEADBEEF)
                    $display("FAIL raw_deadbeef: got %h, want deadbeef", oq[oq.size()-1].rdata);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wait_burst();
        obs_t e;
        xq.delete();
        xq.push_back(mk(1, HTRANS_NON_SEQ, 0, HSIZE_WORD, 32'h0, 32'd0));
        xq.push_back(mk(1, HTRANS_SEQ,     0, HSIZE_WORD, 32'h4, 32'd0));
        xq.push_back(mk(1, HTRANS_SEQ,     0, HSIZE_WORD, 32'h8, 32'd0));
        xq.push_back(mk(1, HTRANS_SEQ,     0, HSIZE_WORD, 32'hC, 32'd0));
        run_xfers(1);
        n_checks++;
        if (timed_out || oq.size() != xq.size() || burst_cycles != 12)
            $display("FAIL wait_burst_cycles: got %0d phases in %0d cycles, want 4 in 12", oq.size(), burst_cycles);
        else n_pass++;
        foreach (oq[i]) begin
            e = model_step(1, xq[i]);
            n_checks++;
            if (oq[i].waits !== e.waits || oq[i].resp_first !== e.resp_first || oq[i].resp_last !== e.resp_last || oq[i].idle_zero !== 1'b1)
                $display("FAIL wait_burst_resp[%0d]: got waits=%0d resp=%b/%b, want waits=%0d resp=%b/%b",
                         i, oq[i].waits, oq[i].resp_first, oq[i].resp_last, e.waits, e.resp_first, e.resp_last);
            else n_pass++;
            n_checks++;
            if (oq[i].rdata !== e.rdata) $display("FAIL wait_burst_data[%0d]: got %h, want %h", i, oq[i].rdata, e.rdata);
            else n_pass++;
        end
    endtask

    task automatic test_byte_lanes();
        obs_t e;
        xfer_t x;
        xq.delete();
        xq.push_back(mk(1, HTRANS_NON_SEQ, 1, HSIZE_WORD, 32'h20, 32'h0));
        xq.push_back(mk(1, HTRANS_NON_SEQ, 1, HSIZE_BYTE, 32'h21, 32'h0000A500));
        xq.push_back(mk(1, HTRANS_NON_SEQ, 0, HSIZE_WORD, 32'h20, 32'h0));
        for (int n = 0; n < 24; n++) begin
            x = mk(1, HTRANS_NON_SEQ, 1, 3'($urandom_range(0, 1)), 32'($urandom_range(0, 4 * DEPTH - 1)), $urandom);
            if (x.size == HSIZE_HALF) x.addr[0] = 1'b0;
            xq.push_back(x);
            xq.push_back(mk(1, HTRANS_SEQ, 0, HSIZE_WORD, {x.addr[31:2], 2'b00}, 32'h0));
        end
        run_xfers(0);
        n_checks++;
        if (timed_out || oq.size() != xq.size())
            $display("FAIL byte_lanes_complete: got %0d of %0d phases", oq.size(), xq.size());
        else n_pass++;
        foreach (oq[i]) begin
            e = model_step(0, xq[i]);
            n_checks++;
            if (oq[i].waits !== e.waits || oq[i].resp_last !== e.resp_last || oq[i].idle_zero !== 1'b1)
                $display("FAIL byte_lanes_resp[%0d]: got waits=%0d resp=%b, want waits=%0d resp=%b",
                         i, oq[i].waits, oq[i].resp_last, e.waits, e.resp_last);
            else n_pass++;
            if (e.chk_rd) begin
                n_checks++;
                if (oq[i].rdata !== e.rdata) $display("FAIL byte_lanes_data[%0d]: got %h, want %h", i, oq[i].rdata, e.rdata);
                else n_pass++;
            end
        end
        if (oq.size() > 2) begin
            n_checks++;
            if (oq[2].rdata !== 32'h0000A500) $display("FAIL byte_a5: got %h, want 0000a500", oq[2].rdata);
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        obs_t e;
        for (int d = 0; d < 2; d++) begin
            xq.delete();
            xq.push_back(mk(1, HTRANS_NON_SEQ, 1, HSIZE_HALF, 32'h3, 32'hFFFFFFFF));
            xq.push_back(mk(1, HTRANS_NON_SEQ, 0, HSIZE_WORD, 32'(4 * DEPTH), 32'h0));
            xq.push_back(mk(1, HTRANS_NON_SEQ, 1, 3'b011, 32'h8, 32'hFFFFFFFF));
            xq.push_back(mk(1, HTRANS_NON_SEQ, 1, HSIZE_WORD, 32'h6, 32'hFFFFFFFF));
            xq.push_back(mk(1, HTRANS_IDLE,    1, HSIZE_WORD, 32'h0, 32'h0));
            xq.push_back(mk(1, HTRANS_NON_SEQ, 0, HSIZE_WORD, 32'h0, 32'h0));
            xq.push_back(mk(1, HTRANS_NON_SEQ, 0, HSIZE_WORD, 32'h4, 32'h0));
            xq.push_back(mk(1, HTRANS_NON_SEQ, 0, HSIZE_WORD, 32'(4 * DEPTH - 4), 32'h0));
            run_xfers(d);
            n_checks++;
            if (timed_out || oq.size() != xq.size())
                $display("FAIL errors_complete d%0d: got %0d of %0d phases", d, oq.size(), xq.size());
            else n_pass++;
            foreach (oq[i]) begin
                e = model_step(d, xq[i]);
                n_checks++;
                if (oq[i].waits !== e.waits || oq[i].resp_first !== e.resp_first || oq[i].resp_last !== e.resp_last || oq[i].idle_zero !== 1'b1)
                    $display("FAIL errors_resp d%0d[%0d]: got waits=%0d resp=%b/%b, want waits=%0d resp=%b/%b",
                             d, i, oq[i].waits, oq[i].resp_first, oq[i].resp_last, e.waits, e.resp_first, e.resp_last);
                else n_pass++;
                n_checks++;
                if (oq[i].rdata !== e.rdata) $display("FAIL errors_data d%0d[%0d]: got %h, want %h", d, i, oq[i].rdata, e.rdata);
                else n_pass++;
            end
        end
    endtask

    task automatic test_busy();
        obs_t e;
        xq.delete();
        xq.push_back(mk(1, HTRANS_NON_SEQ, 0, HSIZE_WORD, 32'h0, 32'h0));
        xq.push_back(mk(1, HTRANS_SEQ,     0, HSIZE_WORD, 32'h4, 32'h0));
        xq.push_back(mk(1, HTRANS_BUSY,    0, HSIZE_WORD, 32'h8, 32'h0));
        xq.push_back(mk(1, HTRANS_SEQ,     0, HSIZE_WORD, 32'h8, 32'h0));
        xq.push_back(mk(0, HTRANS_NON_SEQ, 1, HSIZE_WORD, 32'hC, 32'h12345678));
        xq.push_back(mk(1, HTRANS_SEQ,     0, HSIZE_WORD, 32'hC, 32'h0));
        run_xfers(0);
        n_checks++;
        if (timed_out || oq.size() != xq.size())
            $display("FAIL busy_complete: got %0d of %0d phases", oq.size(), xq.size());
        else n_pass++;
        foreach (oq[i]) begin
            e = model_step(0, xq[i]);
            n_checks++;
            if (oq[i].waits !== e.waits || oq[i].resp_last !== e.resp_last || oq[i].idle_zero !== 1'b1)
                $display("FAIL busy_resp[%0d]: got waits=%0d resp=%b, want waits=%0d resp=%b",
                         i, oq[i].waits, oq[i].resp_last, e.waits, e.resp_last);
            else n_pass++;
            n_checks++;
            if (oq[i].rdata !== e.rdata) $display("FAIL busy_data[%0d]: got %h, want %h", i, oq[i].rdata, e.rdata);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        obs_t e;
        for (int d = 0; d < 3; d++) begin
            xq.delete();
            for (int n = 0; n < 80; n++) xq.push_back(rand_xfer());
            run_xfers(d);
            n_checks++;
            if (timed_out || oq.size() != xq.size())
                $display("FAIL random_complete d%0d: got %0d of %0d phases", d, oq.size(), xq.size());
            else n_pass++;
            foreach (oq[i]) begin
                e = model_step(d, xq[i]);
                n_checks++;
                if (oq[i].waits !== e.waits || oq[i].resp_first !== e.resp_first || oq[i].resp_last !== e.resp_last || oq[i].idle_zero !== 1'b1)
                    $display("FAIL random_resp d%0d[%0d]: got waits=%0d resp=%b/%b, want waits=%0d resp=%b/%b",
                             d, i, oq[i].waits, oq[i].resp_first, oq[i].resp_last, e.waits, e.resp_first, e.resp_last);
                else n_pass++;
                if (e.chk_rd) begin
                    n_checks++;
                    if (oq[i].rdata !== e.rdata) $display("FAIL random_data d%0d[%0d]: got %h, want %h", d, i, oq[i].rdata, e.rdata);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] oldv, newv;
        obs_t e;
        oldv = $urandom;
        newv = ~oldv;
        xq.delete();
        xq.push_back(mk(1, HTRANS_NON_SEQ, 1, HSIZE_WORD, 32'h40, oldv));
        run_xfers(2);
        if (oq.size() > 0) e = model_step(2, xq[0]);
        dsel = 2; hsel = 1'b1; htrans = HTRANS_NON_SEQ; hwrite = 1'b1; hsize = HSIZE_WORD; haddr = 32'h40;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = newv;
        @(posedge clk); #1;
        n_checks++;
        if (obs_ready !== 1'b0) $display("FAIL rst_mid_waiting: got ready=%b, want 0", obs_ready);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs_ready !== 1'b1 || obs_resp !== HRESP_OKAY || obs_rdata !== 32'd0)
            $display("FAIL rst_mid_outputs: got ready=%b resp=%b rdata=%h, want 1/00/0", obs_ready, obs_resp, obs_rdata);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        xq.delete();
        xq.push_back(mk(1, HTRANS_NON_SEQ, 0, HSIZE_WORD, 32'h40, 32'h0));
        run_xfers(2);
        n_checks++;
        if (timed_out || oq.size() != 1 || oq[0].rdata !== oldv || oq[0].waits != 3)
            $display("FAIL rst_mid_old_value: got %h (%0d phases), want %h", (oq.size() > 0) ? oq[0].rdata : 32'hX, oq.size(), oldv);
        else n_pass++;
        if (oq.size() > 0) e = model_step(2, xq[0]);
    endtask

    initial begin
        rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        hsize = HSIZE_WORD; hwdata = '0; dsel = 0;
        test_reset();
        test_word_rw();
        test_wait_burst();
        test_byte_lanes();
        test_errors();
        test_busy();
        test_random();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
